// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS-style R-type ALU with internal HI/LO.
// Single-cycle ops answer at the accept edge; MULT/DIV iterate then FIX.
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [5:0]       funct,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, nstate;

  logic [WIDTH-1:0]   hi, lo, opb, araw, res;
  logic [WIDTH-1:0]   mag_a, mag_b, qfix, rfix;
  logic [2*WIDTH-1:0] p, pfix;
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [SHW-1:0]     cnt;
  logic mul_r, sa, sb, dz;
  logic res_err, mc, sgn, last, accept;

  assign accept = in_valid & in_ready;
  assign last   = cnt == SHW'(WIDTH-1);
  assign sgn    = ~funct[0];
  assign mag_a  = (sgn & a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn & b[WIDTH-1]) ? -b : b;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    mc      = 1'b0;
    unique case (funct)
      6'h00: res = a << shamt;
      6'h02: res = a >> shamt;
      6'h03: res = $signed(a) >>> shamt;
      6'h10: res = hi;
      6'h12: res = lo;
      6'h11, 6'h13: res = a;
      6'h20, 6'h21: res = a + b;
      6'h22, 6'h23: res = a - b;
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h27: res = ~(a | b);
      6'h2a: res = WIDTH'($signed(a) < $signed(b));
      6'h2b: res = WIDTH'(a < b);
      6'h18, 6'h19, 6'h1a, 6'h1b: mc = 1'b1;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (accept && mc) nstate = funct[1] ? DIV : MUL;
      MUL, DIV: if (last) nstate = FIX;
      FIX: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb in_ready = (state == IDLE);

  // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
  assign msum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? opb : '0};
  assign dshift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign ddiff  = dshift - {1'b0, opb};
  assign pfix   = (sa ^ sb) ? -p : p;
  assign qfix   = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rfix   = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; out <= '0;
      out_valid <= 1'b0; err <= 1'b0;
      p <= '0; opb <= '0; araw <= '0; cnt <= '0;
      mul_r <= 1'b0; sa <= 1'b0; sb <= 1'b0; dz <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          if (mc) begin
            p     <= {{WIDTH{1'b0}}, mag_a};
            opb   <= mag_b;
            araw  <= a;
            sa    <= sgn & a[WIDTH-1];
            sb    <= sgn & b[WIDTH-1];
            dz    <= (b == '0);
            mul_r <= ~funct[1];
            cnt   <= '0;
          end else begin
            out       <= res;
            err       <= res_err;
            out_valid <= 1'b1;
            if (funct == 6'h11) hi <= a;
            if (funct == 6'h13) lo <= a;
          end
        end
        MUL: begin
          p   <= {msum, p[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          p   <= {ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0],
                  p[WIDTH-2:0], ~ddiff[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          out_valid <= 1'b1;
          err       <= ~mul_r & dz;
          if (mul_r) begin
            {hi, lo} <= pfix;
            out      <= pfix[WIDTH-1:0];
          end else if (dz) begin
            hi  <= araw;
            lo  <= '1;
            out <= '1;
          end else begin
            hi  <= rfix;
            lo  <= qfix;
            out <= qfix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed + random checks of alu_mc at WIDTH=32 and WIDTH=8
// against an arithmetic reference model and hand-computed literals.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv [2];
  logic [31:0] ta [2];
  logic [31:0] tb_ [2];
  logic [4:0]  tsh [2];
  logic [5:0]  tf [2];

  logic        ir0, ov0, oe0, ir1, ov1, oe1;
  logic [31:0] o32;
  logic [7:0]  o8;

  alu_mc #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir0),
    .a(ta[0]), .b(tb_[0]), .shamt(tsh[0]), .funct(tf[0]),
    .out_valid(ov0), .out(o32), .err(oe0)
  );

  alu_mc #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir1),
    .a(ta[1][7:0]), .b(tb_[1][7:0]),
    .shamt(tsh[1][2:0]), .funct(tf[1]),
    .out_valid(ov1), .out(o8), .err(oe1)
  );

  typedef struct {
    logic [31:0] o;
    logic        e;
    int          cyc;
    bit          lit;
    logic [31:0] lo;
    logic        le;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [5:0] fl [0:21] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h11,
    6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic model(input int w, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh,
                       input logic [31:0] hi_i, input logic [31:0] lo_i,
                       output logic [31:0] o, output logic e,
                       output logic [31:0] hi_o, output logic [31:0] lo_o,
                       output int lat);
    longint mask, ua, ub, sa, sb;
    logic [63:0] pr;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
    o = '0; e = 1'b0; hi_o = hi_i; lo_o = lo_i; lat = 0;
    case (f)
      6'h00: o = 32'((ua << sh) & mask);
      6'h02: o = 32'(ua >> sh);
      6'h03: o = 32'((sa >>> sh) & mask);
      6'h10: o = hi_i;
      6'h12: o = lo_i;
      6'h11: begin o = 32'(ua); hi_o = o; end
      6'h13: begin o = 32'(ua); lo_o = o; end
      6'h20, 6'h21: o = 32'((ua + ub) & mask);
      6'h22, 6'h23: o = 32'((ua - ub) & mask);
      6'h24: o = 32'(ua & ub);
      6'h25: o = 32'(ua | ub);
      6'h26: o = 32'(ua ^ ub);
      6'h27: o = 32'(~(ua | ub) & mask);
      6'h2a: o = {31'b0, sa < sb};
      6'h2b: o = {31'b0, ua < ub};
      6'h18, 6'h19: begin
        pr = (f == 6'h18) ? 64'(sa * sb) : 64'(ua * ub);
        lo_o = 32'(pr & 64'(mask));
        hi_o = 32'((pr >> w) & 64'(mask));
        o = lo_o; lat = w + 1;
      end
      6'h1a, 6'h1b: begin
        lat = w + 1;
        if (ub == 0) begin
          lo_o = 32'(mask); hi_o = 32'(ua); e = 1'b1;
        end else if (f == 6'h1a) begin
          lo_o = 32'((sa / sb) & mask);
          hi_o = 32'((sa % sb) & mask);
        end else begin
          lo_o = 32'(ua / ub);
          hi_o = 32'(ua % ub);
        end
        o = lo_o;
      end
      default: e = 1'b1;
    endcase
  endtask

  function automatic logic rdy(int d);
    return d ? ir1 : ir0;
  endfunction

  task automatic send(input int d, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input bit lit,
                      input logic [31:0] lo, input logic le);
    int w, n, lat;
    exp_t x;
    logic [31:0] o, hn, ln;
    logic e;
    w = d ? 8 : 32;
    n = 0;
    tf[d] = f; ta[d] = a; tb_[d] = b;
    tsh[d] = sh & 5'(w - 1);
    iv[d] = 1'b1;
    while (!rdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: ready=0 want 1", d);
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(w, f, a, b, tsh[d], mhi[d], mlo[d], o, e, hn, ln, lat);
    mhi[d] = hn; mlo[d] = ln;
    x.o = o; x.e = e; x.cyc = cyc + lat;
    x.lit = lit; x.lo = lo; x.le = le;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic cmp(input int d);
    exp_t x;
    logic [31:0] o;
    logic e;
    o = d ? {24'b0, o8} : o32;
    e = d ? oe1 : oe0;
    if ((d == 0) ? q0.size() == 0 : q1.size() == 0) begin
      checks++; errors++;
      $display("FAIL stray_out_valid dut%0d: out=%h, none expected", d, o);
      return;
    end
    x = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("out%0d", d), o, x.o);
    check($sformatf("err%0d", d), {31'b0, e}, {31'b0, x.e});
    check($sformatf("latency%0d", d), cyc, x.cyc);
    if (x.lit) begin
      check($sformatf("lit_out%0d", d), o, x.lo);
      check($sformatf("lit_err%0d", d), {31'b0, e}, {31'b0, x.le});
    end
  endtask

  always @(negedge clk) begin
    if (ov0) cmp(0);
    if (ov1) cmp(1);
  end

  task automatic chk_reset(input string nm);
    check({nm, "_ready32"}, {31'b0, ir0}, 32'd1);
    check({nm, "_valid32"}, {31'b0, ov0}, 32'd0);
    check({nm, "_out32"}, o32, 32'd0);
    check({nm, "_ready8"}, {31'b0, ir1}, 32'd1);
    check({nm, "_valid8"}, {31'b0, ov1}, 32'd0);
    check({nm, "_out8"}, {24'b0, o8}, 32'd0);
  endtask

  initial begin
    logic bsy;
    int n;
    logic [31:0] ra, rb;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ta[d] = '0; tb_[d] = '0; tsh[d] = '0; tf[d] = '0;
      mhi[d] = '0; mlo[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 6'h20, 32'h7fffffff, 32'd1, 5'd0, 1, 32'h80000000, 1'b0);
    send(0, 6'h2a, 32'hffffffff, 32'd1, 5'd0, 1, 32'd1, 1'b0);
    send(0, 6'h2b, 32'hffffffff, 32'd1, 5'd0, 1, 32'd0, 1'b0);
    send(0, 6'h03, 32'h80000000, 32'd0, 5'd4, 1, 32'hf8000000, 1'b0);
    send(0, 6'h3f, 32'h12345678, 32'h1, 5'd0, 1, 32'd0, 1'b1);
    send(0, 6'h00, 32'h00000003, 32'd0, 5'd31, 1, 32'h80000000, 1'b0);
    send(0, 6'h02, 32'h80000000, 32'd0, 5'd31, 1, 32'd1, 1'b0);
    send(0, 6'h23, 32'd0, 32'd1, 5'd0, 1, 32'hffffffff, 1'b0);
    send(0, 6'h27, 32'h0f0f0000, 32'h000000ff, 5'd0, 1, 32'hf0f0ff00, 1'b0);
    send(0, 6'h11, 32'hdeadbeef, 32'd0, 5'd0, 1, 32'hdeadbeef, 1'b0);
    send(0, 6'h13, 32'h12345678, 32'd0, 5'd0, 1, 32'h12345678, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'hdeadbeef, 1'b0);
    send(0, 6'h12, 32'd0, 32'd0, 5'd0, 1, 32'h12345678, 1'b0);

    send(0, 6'h18, 32'hfffffffd, 32'd7, 5'd0, 1, 32'hffffffeb, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'hffffffff, 1'b0);
    send(0, 6'h12, 32'd0, 32'd0, 5'd0, 1, 32'hffffffeb, 1'b0);
    send(0, 6'h19, 32'hffffffff, 32'hffffffff, 5'd0, 1, 32'd1, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'hfffffffe, 1'b0);
    send(0, 6'h1a, 32'hfffffff9, 32'd2, 5'd0, 1, 32'hfffffffd, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'hffffffff, 1'b0);
    send(0, 6'h1a, 32'h80000000, 32'hffffffff, 5'd0, 1, 32'h80000000, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'd0, 1'b0);
    send(0, 6'h1b, 32'd100, 32'd7, 5'd0, 1, 32'd14, 1'b0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'd2, 1'b0);

    send(0, 6'h1b, 32'd5, 32'd0, 5'd0, 1, 32'hffffffff, 1'b1);
    tf[0] = 6'h10;
    iv[0] = 1'b1;
    bsy = 1'b0;
    repeat (33) begin
      @(negedge clk);
      if (ir0) bsy = 1'b1;
    end
    check("busy_ready_low", {31'b0, bsy}, 32'd0);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'd5, 1'b0);
    send(0, 6'h12, 32'd0, 32'd0, 5'd0, 1, 32'hffffffff, 1'b0);

    send(0, 6'h11, 32'h00001234, 32'd0, 5'd0, 1, 32'h00001234, 1'b0);
    send(0, 6'h1a, 32'd1000, 32'd3, 5'd0, 0, 32'd0, 1'b0);
    iv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    for (int d = 0; d < 2; d++) begin
      mhi[d] = '0; mlo[d] = '0;
    end
    #2;
    chk_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'd0, 1'b0);
    send(0, 6'h12, 32'd0, 32'd0, 5'd0, 1, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      send(0, fl[$urandom_range(0, 21)], ra, rb, 5'($urandom), 0, 0, 0);
    end
    send(0, 6'h10, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1'b0);
    iv[0] = 1'b0;

    send(1, 6'h19, 32'hff, 32'hff, 5'd0, 1, 32'h01, 1'b0);
    send(1, 6'h10, 32'd0, 32'd0, 5'd0, 1, 32'hfe, 1'b0);
    send(1, 6'h1a, 32'h80, 32'hff, 5'd0, 1, 32'h80, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(0, 255);
      send(1, fl[$urandom_range(17, 20)], ra, rb, 5'd0, 0, 0, 0);
      send(1, 6'h10, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1'b0);
    end
    for (int i = 0; i < 16; i++)
      send(1, fl[$urandom_range(0, 21)], $urandom, $urandom,
           5'($urandom), 0, 0, 0);
    iv[1] = 1'b0;

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending %0d/%0d want 0",
               q0.size(), q1.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
